imm_field_packer: RTL and testbench

- Inverse of the datapath sign extender: takes a 64-bit signed immediate plus the 2-bit immediate-format select and inserts the immediate into the correct bit field of a 32-bit LEGv8 instruction word.
- Flags immediates that do not fit the target field.
- Sits in the instruction-memory loader path: a program source streams (base word, immediate, format) in; packed words stream out with sequential word addresses, buffered in a 2-entry output FIFO.

---
 rtl/imm_field_packer.sv | 141 ++++++++++++++
 tb/tb_imm_field_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_field_packer.sv
// imm_field_packer: inserts a signed immediate into the immediate field of a
// 32-bit LEGv8 instruction word, flags values that do not fit, and queues the
// packed word with a dense sequential word address in a 2-entry output FIFO.
module imm_field_packer #(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_base,
  input  logic [63:0]       in_imm,
  input  logic [1:0]        in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_range_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  // Copy the base word and overwrite only the field selected by ctrl.
  // Out-of-range immediates are simply truncated into the field.
  function automatic logic [31:0] pack_field(
    input logic [31:0] base,
    input logic [63:0] imm,
    input logic [1:0]  ctrl
  );
    logic [31:0] inst;
    inst = base;
    case (ctrl)
      2'b00:   inst[21:10] = imm[11:0];
      2'b01:   inst[20:12] = imm[8:0];
      2'b10:   inst[25:0]  = imm[25:0];
      2'b11:   inst[23:5]  = imm[18:0];
      default: inst = base;
    endcase
    return inst;
  endfunction

  // An immediate fits when every bit from the field's sign bit upward is a
  // copy of that sign bit, i.e. sign extension of the field restores it.
  function automatic logic imm_fits(
    input logic [63:0] imm,
    input logic [1:0]  ctrl
  );
    logic fits;
    case (ctrl)
      2'b00:   fits = (&imm[63:11]) | ~(|imm[63:11]);
      2'b01:   fits = (&imm[63:8])  | ~(|imm[63:8]);
      2'b10:   fits = (&imm[63:25]) | ~(|imm[63:25]);
      2'b11:   fits = (&imm[63:18]) | ~(|imm[63:18]);
      default: fits = 1'b0;
    endcase
    return fits;
  endfunction

  logic [31:0]       inst_mem_r [2];
  logic [ADDR_W-1:0] addr_mem_r [2];
  logic              err_mem_r  [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic [ADDR_W-1:0] next_addr_r;
  logic [ERR_W-1:0]  err_count_r;

  logic [31:0]       packed_inst_s;
  logic              range_err_s;
  logic              push_s;
  logic              pop_s;
  logic              in_ready_s;
  logic              out_valid_s;

  // Combinational packing and range check of the beat on the input.
  always_comb begin
    packed_inst_s = pack_field(in_base, in_imm, in_ctrl);
    range_err_s   = ~imm_fits(in_imm, in_ctrl);
  end

  // Handshake decode; in_ready depends only on stored occupancy (and is held
  // low while Reset is asserted), never on out_ready.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    if (Reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (count_r != 2'd2);
    end
    out_valid_s = (count_r != 2'd0);
    push_s      = in_valid && in_ready_s;
    pop_s       = out_valid_s && out_ready;
  end

  // FIFO storage, pointers, occupancy, address counter and error counter.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        inst_mem_r[i] <= 32'd0;
        addr_mem_r[i] <= {ADDR_W{1'b0}};
        err_mem_r[i]  <= 1'b0;
      end
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      next_addr_r <= {ADDR_W{1'b0}};
      err_count_r <= {ERR_W{1'b0}};
    end else begin
      if (push_s) begin
        inst_mem_r[wr_ptr_r] <= packed_inst_s;
        addr_mem_r[wr_ptr_r] <= next_addr_r;
        err_mem_r[wr_ptr_r]  <= range_err_s;
        wr_ptr_r             <= ~wr_ptr_r;
        // Addresses advance for every accepted beat so the image stays dense.
        next_addr_r          <= next_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (range_err_s && (err_count_r != ERR_MAX)) begin
          err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
        end
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign in_ready      = in_ready_s;
  assign out_valid     = out_valid_s;
  assign out_inst      = inst_mem_r[rd_ptr_r];
  assign out_addr      = addr_mem_r[rd_ptr_r];
  assign out_range_err = err_mem_r[rd_ptr_r];
  assign err_count     = err_count_r;

endmodule

// File: tb/tb_imm_field_packer.sv
// Self-checking bench for imm_field_packer: a table of hand-packed vectors
// streamed through with out_ready high, then directed backpressure, reset and
// wrap/saturation sequences (the latter on a narrow-counter instance).
module tb_imm_field_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_base;
  logic [63:0] in_imm;
  logic [1:0]  in_ctrl;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [7:0]  out_addr;
  logic        out_range_err;
  logic [7:0]  err_count;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_inst;
  logic [1:0]  s_out_addr;
  logic        s_out_range_err;
  logic [1:0]  s_err_count;

  int total = 0;
  int bad   = 0;

  imm_field_packer #(.ADDR_W(8), .ERR_W(8)) dut (
    .CLK(clk), .Reset(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .out_range_err(out_range_err), .err_count(err_count)
  );

  imm_field_packer #(.ADDR_W(2), .ERR_W(2)) dut_small (
    .CLK(clk), .Reset(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_base(in_base), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_inst(s_out_inst), .out_addr(s_out_addr),
    .out_range_err(s_out_range_err), .err_count(s_err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] base;
    logic [63:0] imm;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [1:0] c, input logic [31:0] b, input logic [63:0] i);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_base  = b;
    in_imm   = i;
  endtask

  initial begin
    int err_model;
    vecs[0]  = '{2'b00, 32'h9100_0000, 64'd5,                   32'h9100_1400, 1'b0};
    vecs[1]  = '{2'b01, 32'hF840_0000, 64'hFFFF_FFFF_FFFF_FFF8, 32'hF85F_8000, 1'b0};
    vecs[2]  = '{2'b01, 32'hF840_0000, 64'd256,                 32'hF850_0000, 1'b1};
    vecs[3]  = '{2'b10, 32'h1400_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h17FF_FFFF, 1'b0};
    vecs[4]  = '{2'b11, 32'hB400_0000, 64'h0004_0000,           32'hB480_0000, 1'b1};
    vecs[5]  = '{2'b11, 32'hB400_0000, 64'h0003_FFFF,           32'hB47F_FFE0, 1'b0};
    vecs[6]  = '{2'b00, 32'h9100_0000, 64'd2047,                32'h911F_FC00, 1'b0};
    vecs[7]  = '{2'b00, 32'h9100_0000, 64'hFFFF_FFFF_FFFF_F800, 32'h9120_0000, 1'b0};
    vecs[8]  = '{2'b00, 32'h9100_0000, 64'd2048,                32'h9120_0000, 1'b1};
    vecs[9]  = '{2'b00, 32'h913F_FC1F, 64'd0,                   32'h9100_001F, 1'b0};
    vecs[10] = '{2'b10, 32'h1400_0000, 64'h0000_0000_0200_0000, 32'h1600_0000, 1'b1};
    vecs[11] = '{2'b10, 32'h1400_0000, 64'hFFFF_FFFF_FE00_0000, 32'h1600_0000, 1'b0};
    vecs[12] = '{2'b01, 32'hF840_0000, 64'hFFFF_FFFF_FFFF_FEFF, 32'hF84F_F000, 1'b1};

    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_base = 32'd0;
    in_imm = 64'd0; in_ctrl = 2'b00; out_ready = 1'b1;
    #1;
    check("ready_during_reset", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_range_err", out_range_err, 0);
    check("rst_err_count", err_count, 0);

    // Streaming vectors: each cycle pushes a new beat while popping the last.
    err_model = 0;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].ctrl, vecs[i].base, vecs[i].imm);
      out_ready = 1'b1;
      tick();
      if (vecs[i].exp_err) err_model++;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_addr", i), out_addr, i);
      check($sformatf("vec%0d_err", i), out_range_err, vecs[i].exp_err);
      check($sformatf("vec%0d_errcnt", i), err_count, err_model);
      check($sformatf("vec%0d_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);

    // Backpressure: fill the FIFO, stall a third beat, then release.
    do_reset();
    out_ready = 1'b0;
    drive(2'b00, 32'h9100_0000, 64'd1);
    tick();
    check("bp_head_addr0", out_addr, 0);
    check("bp_head_inst0", out_inst, 32'h9100_0400);
    drive(2'b00, 32'h9100_0000, 64'd2);
    tick();
    check("bp_full_ready", in_ready, 0);
    check("bp_full_addr", out_addr, 0);
    drive(2'b00, 32'h9100_0000, 64'd3);
    tick();
    check("bp_stall_ready", in_ready, 0);
    check("bp_stall_addr", out_addr, 0);
    check("bp_stall_inst", out_inst, 32'h9100_0400);
    check("bp_stall_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("bp_rel1_addr", out_addr, 1);
    check("bp_rel1_inst", out_inst, 32'h9100_0800);
    check("bp_rel1_ready", in_ready, 1);
    tick();
    check("bp_rel2_addr", out_addr, 2);
    check("bp_rel2_inst", out_inst, 32'h9100_0C00);
    in_valid = 1'b0;
    tick();
    check("bp_empty", out_valid, 0);

    // Reset with two entries queued and a beat offered in the reset cycle.
    out_ready = 1'b0;
    drive(2'b01, 32'hF840_0000, 64'd300);
    tick();
    tick();
    check("mid_full_errcnt", err_count, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_post_valid", out_valid, 0);
    check("mid_post_errcnt", err_count, 0);
    check("mid_post_ready", in_ready, 1);
    drive(2'b00, 32'h9100_0000, 64'd7);
    tick();
    check("mid_first_addr", out_addr, 0);
    check("mid_first_inst", out_inst, 32'h9100_1C00);
    in_valid = 1'b0;

    // Address wrap and error saturation on the narrow instance.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 32'h0000_0000, 64'd4096);
      #1;
      check($sformatf("wrap%0d_ready", i), s_in_ready, 1);
      tick();
      check($sformatf("wrap%0d_valid", i), s_out_valid, 1);
      check($sformatf("wrap%0d_addr", i), s_out_addr, i % 4);
      check($sformatf("wrap%0d_err", i), s_out_range_err, 1);
      check($sformatf("wrap%0d_inst", i), s_out_inst, 32'h0000_0000);
      check($sformatf("wrap%0d_errcnt", i), s_err_count, (i + 1 > 3) ? 3 : i + 1);
    end
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
